// File: rtl/scroll_line_fetcher.sv
// Turns per-frame scroll offsets into one burst-aligned DDR3 read sequence per display line.
// Optional `SCROLL_FETCH_VWRAP_EN: rows past the bitmap bottom wrap to the top instead of clamping.
module scroll_line_fetcher #(
  parameter int ADDR_SIZE  = 29,
  parameter int PIX_SHIFT  = 1,
  parameter int BURST_LOG2 = 4
) (
  input  logic                  CMD_CLK,
  input  logic                  reset,
  input  logic                  VID_xena_in,
  input  logic                  VID_yena_in,
  input  logic [ADDR_SIZE-1:0]  DISP_bitmap_base,
  input  logic [15:0]           DISP_bitmap_width,
  input  logic [15:0]           DISP_bitmap_height,
  input  logic [13:0]           DISP_xsize,
  input  logic [13:0]           DISP_ysize,
  input  logic signed [13:0]    scroll_xpos,
  input  logic signed [13:0]    scroll_ypos,
  input  logic                  CMD_busy,
  output logic                  CMD_ena,
  output logic [ADDR_SIZE-1:0]  CMD_addr,
  output logic                  CMD_buf_sel,
  output logic [9:0]            CMD_word_idx,
  output logic                  frame_start,
  output logic                  fetch_late
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL1 = 2'd1;
  localparam logic [1:0] S_MUL2 = 2'd2;
  localparam logic [1:0] S_REQ  = 2'd3;

  logic [1:0]           state;
  logic                 xena_dl, yena_dl, hs, act, frame_ok;
  logic [13:0]          xs, ys;
  logic [14:0]          line;
  logic                 bank;
  logic [16:0]          row_q;
  logic [15:0]          wid_q;
  logic [17:0]          rem;

  logic                 hs_d, trig;
  logic [14:0]          line_nx;
  logic [16:0]          row_raw, row_fix;
  logic [32:0]          prod;
  logic [33:0]          pix;
  logic [ADDR_SIZE-1:0] byte_addr, start_addr;
  logic [17:0]          span, nwords;

  assign hs_d    = VID_xena_in & ~xena_dl;
  assign line_nx = line + 15'd1;
  // Active-line fetches need a prior frame snapshot, so nothing is fetched straight out of reset.
  assign trig    = hs & (frame_start | (act & frame_ok & (line_nx < {1'b0, DISP_ysize})));
  assign row_raw = {3'b000, ys} + {2'b00, line};

  always_comb begin
    row_fix = row_raw;
    if (row_raw >= {1'b0, DISP_bitmap_height}) begin
`ifdef SCROLL_FETCH_VWRAP_EN
      row_fix = row_raw - {1'b0, DISP_bitmap_height};
`else
      row_fix = {1'b0, DISP_bitmap_height - 16'd1};
`endif
    end
  end

  assign prod       = 33'(row_q) * 33'(wid_q);
  assign pix        = 34'(prod) + 34'(xs);
  assign byte_addr  = DISP_bitmap_base + ADDR_SIZE'(pix << PIX_SHIFT);
  assign start_addr = {byte_addr[ADDR_SIZE-1:BURST_LOG2], BURST_LOG2'(0)};
  // Leading misalignment bytes plus the line payload, rounded up to whole bursts.
  assign span       = 18'(byte_addr[BURST_LOG2-1:0]) + (18'(DISP_xsize) << PIX_SHIFT)
                    + 18'((1 << BURST_LOG2) - 1);
  assign nwords     = span >> BURST_LOG2;

  always_ff @(posedge CMD_CLK) begin
    if (reset) begin
      state        <= S_IDLE;
      xena_dl      <= 1'b0;
      yena_dl      <= 1'b0;
      hs           <= 1'b0;
      act          <= 1'b0;
      frame_ok     <= 1'b0;
      frame_start  <= 1'b0;
      fetch_late   <= 1'b0;
      xs           <= '0;
      ys           <= '0;
      line         <= '0;
      bank         <= 1'b0;
      row_q        <= '0;
      wid_q        <= '0;
      rem          <= '0;
      CMD_ena      <= 1'b0;
      CMD_addr     <= '0;
      CMD_buf_sel  <= 1'b0;
      CMD_word_idx <= '0;
    end else begin
      xena_dl     <= VID_xena_in;
      hs          <= hs_d;
      frame_start <= hs_d & ~VID_yena_in & yena_dl;
      act         <= hs_d & VID_yena_in;
      if (hs_d) yena_dl <= VID_yena_in;

      if (frame_start) begin
        xs       <= scroll_xpos[13] ? 14'd0 : scroll_xpos;
        ys       <= scroll_ypos[13] ? 14'd0 : scroll_ypos;
        line     <= '0;
        bank     <= 1'b0;
        frame_ok <= 1'b1;
      end else if (act) begin
        line <= line_nx;
        bank <= ~bank;
      end

      if (trig) begin
        if (state != S_IDLE) fetch_late <= 1'b1;
        state   <= S_MUL1;
        CMD_ena <= 1'b0;
      end else begin
        case (state)
          S_MUL1: begin
            row_q <= row_fix;
            wid_q <= DISP_bitmap_width;
            state <= S_MUL2;
          end
          S_MUL2: begin
            CMD_addr     <= start_addr;
            CMD_word_idx <= '0;
            CMD_buf_sel  <= bank;
            rem          <= nwords;
            CMD_ena      <= (nwords != 18'd0);
            state        <= (nwords != 18'd0) ? S_REQ : S_IDLE;
          end
          S_REQ: begin
            if (!CMD_busy) begin
              CMD_addr     <= CMD_addr + ADDR_SIZE'(1 << BURST_LOG2);
              CMD_word_idx <= CMD_word_idx + 10'd1;
              rem          <= rem - 18'd1;
              if (rem == 18'd1) begin
                state   <= S_IDLE;
                CMD_ena <= 1'b0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scroll_line_fetcher.sv
// Directed bench for scroll_line_fetcher: frame snapshot, line addressing, handshake, late abort, wrap, reset.
module tb_scroll_line_fetcher;

  logic               CMD_CLK = 1'b0;
  logic               reset = 1'b1;
  logic               VID_xena_in = 1'b0;
  logic               VID_yena_in = 1'b0;
  logic [28:0]        base = '0;
  logic [15:0]        width = 16'd2560;
  logic [15:0]        height = 16'd1440;
  logic [13:0]        xsize = 14'd1920;
  logic [13:0]        ysize = 14'd1080;
  logic signed [13:0] xpos = '0;
  logic signed [13:0] ypos = '0;
  logic               CMD_busy = 1'b0;
  logic               CMD_ena, CMD_buf_sel, frame_start, fetch_late;
  logic [28:0]        CMD_addr;
  logic [9:0]         CMD_word_idx;

  int errors = 0;
  int checks = 0;

  scroll_line_fetcher dut (
    .CMD_CLK(CMD_CLK), .reset(reset),
    .VID_xena_in(VID_xena_in), .VID_yena_in(VID_yena_in),
    .DISP_bitmap_base(base), .DISP_bitmap_width(width), .DISP_bitmap_height(height),
    .DISP_xsize(xsize), .DISP_ysize(ysize),
    .scroll_xpos(xpos), .scroll_ypos(ypos),
    .CMD_busy(CMD_busy), .CMD_ena(CMD_ena), .CMD_addr(CMD_addr),
    .CMD_buf_sel(CMD_buf_sel), .CMD_word_idx(CMD_word_idx),
    .frame_start(frame_start), .fetch_late(fetch_late)
  );

  always #5 CMD_CLK = ~CMD_CLK;

`define CHK(tag, o, e) begin \
    checks++; \
    assert (64'(o) === 64'(e)) else begin \
      errors++; \
      $error("FAIL %s: got %0d want %0d", tag, 64'(o), 64'(e)); \
    end \
  end

  // Aligned start byte of an unwrapped bitmap row at 16bpp with 16-byte bursts.
  function automatic longint ebyte(input longint row, input longint x);
    longint b;
    b = longint'(base) + ((row * longint'(width) + x) << 1);
    return b & ~longint'(15);
  endfunction

  // Raise xena for one cycle; returns on the negedge where the detected edge is visible.
  task automatic hsync(input bit y);
    VID_xena_in = 1'b1;
    VID_yena_in = y;
    @(negedge CMD_CLK);
    VID_xena_in = 1'b0;
  endtask

  // Follow one line's burst: every accepted word must be the next address/index in order.
  task automatic collect(input string tag, input longint start, input int n, input bit sel, input bit tog);
    int k = 0;
    int bad = 0;
    bit seen = 0;
    bit held = 0;
    logic [28:0] pa = '0;
    logic [9:0]  pi = '0;
    logic        pb = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      CMD_busy = tog ? ~CMD_busy : 1'b0;
      if (CMD_ena) begin
        seen = 1;
        if (held && (CMD_addr !== pa || CMD_word_idx !== pi || CMD_buf_sel !== pb)) bad++;
        held = CMD_busy;
        pa = CMD_addr; pi = CMD_word_idx; pb = CMD_buf_sel;
        if (!CMD_busy) begin
          if (CMD_addr !== 29'(start + 16 * k) || CMD_word_idx !== 10'(k) || CMD_buf_sel !== sel) bad++;
          k++;
        end
      end else if (seen) begin
        break;
      end
      @(negedge CMD_CLK);
    end
    CMD_busy = 1'b0;
    `CHK({tag, "/seen"}, seen, 1)
    `CHK({tag, "/words"}, k, n)
    `CHK({tag, "/seq"}, bad, 0)
  endtask

  initial begin
    int cnt;
    bit found;
    longint wrap_addr;
`ifdef SCROLL_FETCH_VWRAP_EN
    wrap_addr = 0;
`else
    wrap_addr = 7367680;
`endif

    repeat (3) @(negedge CMD_CLK);
    `CHK("rst/ena", CMD_ena, 0)
    `CHK("rst/addr", CMD_addr, 0)
    `CHK("rst/idx", CMD_word_idx, 0)
    `CHK("rst/sel", CMD_buf_sel, 0)
    `CHK("rst/fs", frame_start, 0)
    `CHK("rst/late", fetch_late, 0)
    reset = 1'b0;
    repeat (2) @(negedge CMD_CLK);

    // Active line before any frame snapshot: no fetch.
    hsync(1);
    cnt = 0;
    repeat (8) begin if (CMD_ena) cnt++; @(negedge CMD_CLK); end
    `CHK("pre/noena", cnt, 0)

    // Frame start, zero offset: latency then 240 words from 0.
    hsync(0);
    `CHK("l0/fs", frame_start, 1)
    `CHK("l0/ena_hs", CMD_ena, 0)
    @(negedge CMD_CLK);
    `CHK("l0/ena_m1", CMD_ena, 0)
    @(negedge CMD_CLK);
    `CHK("l0/ena_m2", CMD_ena, 0)
    @(negedge CMD_CLK);
    `CHK("l0/ena_req", CMD_ena, 1)
    `CHK("l0/fs_pulse", frame_start, 0)
    collect("l0", 0, 240, 0, 0);
    repeat (4) @(negedge CMD_CLK);
    hsync(1);
    collect("l1", 5120, 240, 1, 0);

    // Offset frame: xs=3, ys=10.
    xpos = 14'sd3; ypos = 14'sd10;
    repeat (4) @(negedge CMD_CLK);
    hsync(0);
    collect("off_l0", 51200, 241, 0, 0);
    hsync(1);
    collect("off_l1", 56320, 241, 1, 0);

    // Busy toggling on line 2 (row 12).
    hsync(1);
    collect("busy_l2", 61440, 241, 0, 1);

    // Late fetch: line 3 stalls under busy, next hs aborts it.
    CMD_busy = 1'b1;
    hsync(1);
    repeat (40) @(negedge CMD_CLK);
    `CHK("late/ena_hold", CMD_ena, 1)
    `CHK("late/idx_hold", CMD_word_idx, 0)
    `CHK("late/addr_hold", CMD_addr, 66560)
    `CHK("late/sel_hold", CMD_buf_sel, 1)
    `CHK("late/flag0", fetch_late, 0)
    hsync(1);
    @(negedge CMD_CLK);
    `CHK("late/flag1", fetch_late, 1)
    `CHK("late/ena_m1", CMD_ena, 0)
    CMD_busy = 1'b0;
    collect("late_l4", 71680, 241, 0, 0);

    // Short lines for wrap test; line 5 (row 15) lead 6 -> 3 words.
    xsize = 14'd16;
    repeat (2) @(negedge CMD_CLK);
    hsync(1);
    collect("short_l5", 76800, 3, 1, 0);
    xpos = 14'sd0; ypos = 14'sd1430;
    hsync(0);
    collect("wrap_l0", 7321600, 2, 0, 0);
    for (int l = 1; l < 10; l++) begin
      hsync(1);
      collect("wrap_ln", ebyte(1430 + l, 0), 2, l[0], 0);
    end
    hsync(1);
    collect("wrap_l10", wrap_addr, 2, 0, 0);

    // Reset during word 100 of line 11 (row 1441).
    xsize = 14'd1920;
    repeat (2) @(negedge CMD_CLK);
    hsync(1);
    found = 0;
    for (int c = 0; c < 400; c++) begin
      if (CMD_ena && CMD_word_idx == 10'd100) begin found = 1; break; end
      @(negedge CMD_CLK);
    end
    `CHK("rmid/found", found, 1)
`ifdef SCROLL_FETCH_VWRAP_EN
    `CHK("rmid/addr100", CMD_addr, 6720)
`else
    `CHK("rmid/addr100", CMD_addr, 7369280)
`endif
    reset = 1'b1;
    @(negedge CMD_CLK);
    `CHK("rmid/ena", CMD_ena, 0)
    `CHK("rmid/addr", CMD_addr, 0)
    `CHK("rmid/idx", CMD_word_idx, 0)
    `CHK("rmid/sel", CMD_buf_sel, 0)
    `CHK("rmid/fs", frame_start, 0)
    `CHK("rmid/late", fetch_late, 0)
    reset = 1'b0;
    repeat (2) @(negedge CMD_CLK);
    hsync(1);
    cnt = 0;
    repeat (8) begin if (CMD_ena) cnt++; @(negedge CMD_CLK); end
    `CHK("rpost/noena", cnt, 0)
    hsync(0);
    `CHK("rpost/fs", frame_start, 1)
    repeat (3) @(negedge CMD_CLK);
    `CHK("rpost/ena", CMD_ena, 1)
    collect("rpost_l0", 7321600, 240, 0, 0);

    repeat (3) @(negedge CMD_CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
